ttt_move_sequencer: RTL and testbench

//  Front end that drives the Tic_Tac_Toe game core's move interface (play/comp/player/computer).

---
 rtl/ttt_pkg.sv | 70 +++++++
 rtl/ttt_move_pick.sv | 72 +++++++
 rtl/ttt_move_sequencer.sv | 155 +++++++++++++++
 tb/tb_ttt_move_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Package: ttt_pkg
// Shared encodings and board helpers for the tic-tac-toe move sequencer.
//   cell_e      : 2-bit cell code as carried on the core board bus
//   winner_e    : 2-bit game result code returned by the core
//   win_line()  : the three cell indices of each of the 8 winning lines
//   cell_at()   : extract one cell from the 18-bit board (out-of-range reads as occupied)
//   line_win()  : true when any line holds three of the given mark
package ttt_pkg;

    typedef enum logic [1:0] {
        CellEmpty  = 2'b00,
        CellPlayer = 2'b01,
        CellComp   = 2'b10,
        CellBad    = 2'b11
    } cell_e;

    typedef enum logic [1:0] {
        WinNone   = 2'b00,
        WinPlayer = 2'b01,
        WinComp   = 2'b10,
        WinDraw   = 2'b11
    } winner_e;

    localparam int         NumCells   = 9;
    localparam int         NumLines   = 8;
    localparam logic [3:0] NoCell     = 4'hF;
    // Bit i set for cell i.
    localparam logic [8:0] CornerMask = 9'h145;  // cells 0,2,6,8
    localparam logic [8:0] EdgeMask   = 9'h0AA;  // cells 1,3,5,7

    // Returns {a, b, c} cell indices of line l, 4 bits each.
    function automatic logic [11:0] win_line(input int l);
        logic [11:0] t;
        case (l)
            0:       t = {4'd0, 4'd1, 4'd2};
            1:       t = {4'd3, 4'd4, 4'd5};
            2:       t = {4'd6, 4'd7, 4'd8};
            3:       t = {4'd0, 4'd3, 4'd6};
            4:       t = {4'd1, 4'd4, 4'd7};
            5:       t = {4'd2, 4'd5, 4'd8};
            6:       t = {4'd0, 4'd4, 4'd8};
            default: t = {4'd2, 4'd4, 4'd6};
        endcase
        return t;
    endfunction

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        logic [1:0] c;
        c = CellBad;
        for (int k = 0; k < NumCells; k++) begin
            if (idx == 4'(k)) c = b[2*k +: 2];
        end
        return c;
    endfunction

    function automatic logic line_win(input logic [17:0] b, input cell_e mark);
        logic        hit;
        logic [11:0] t;
        hit = 1'b0;
        for (int l = 0; l < NumLines; l++) begin
            t = win_line(l);
            if (cell_at(b, t[11:8]) == mark && cell_at(b, t[7:4]) == mark &&
                cell_at(b, t[3:0]) == mark) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ttt_move_pick.sv
// Module: ttt_move_pick
// Combinational computer-move chooser.
//   i_board    [17:0] board to evaluate (player move already overlaid)
//   i_strategy        0: lowest free cell; 1: win > block > centre > corner > edge
//   o_cell     [3:0]  chosen cell 0..8, or 4'hF when no cell is free
module ttt_move_pick
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    input  logic        i_strategy,
    output logic [3:0]  o_cell
);

    logic [8:0] w_free;
    logic [8:0] w_win;
    logic [8:0] w_block;

    // Cells that would complete a line of three of mark m.
    function automatic logic [8:0] finish_mask(input logic [17:0] b, input cell_e m);
        logic [8:0]  mask;
        logic [11:0] t;
        logic [1:0]  ca, cb, cc;
        mask = '0;
        for (int l = 0; l < NumLines; l++) begin
            t  = win_line(l);
            ca = cell_at(b, t[11:8]);
            cb = cell_at(b, t[7:4]);
            cc = cell_at(b, t[3:0]);
            if (ca == m && cb == m && cc == CellEmpty) mask[t[3:0]]  = 1'b1;
            if (ca == m && cc == m && cb == CellEmpty) mask[t[7:4]]  = 1'b1;
            if (cb == m && cc == m && ca == CellEmpty) mask[t[11:8]] = 1'b1;
        end
        return mask;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [8:0] m);
        logic [3:0] r;
        r = NoCell;
        for (int i = NumCells - 1; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        w_free = '0;
        for (int k = 0; k < NumCells; k++) begin
            w_free[k] = (i_board[2*k +: 2] == CellEmpty);
        end
        w_win   = finish_mask(i_board, CellComp);
        w_block = finish_mask(i_board, CellPlayer);
    end

    always_comb begin
        o_cell = NoCell;
        if (!i_strategy) begin
            o_cell = lowest_set(w_free);
        end else if (|w_win) begin
            o_cell = lowest_set(w_win);
        end else if (|w_block) begin
            o_cell = lowest_set(w_block);
        end else if (w_free[4]) begin
            o_cell = 4'd4;
        end else if (|(w_free & CornerMask)) begin
            o_cell = lowest_set(w_free & CornerMask);
        end else begin
            // Yields NoCell when the board is full.
            o_cell = lowest_set(w_free & EdgeMask);
        end
    end

endmodule

// File: rtl/ttt_move_sequencer.sv
// Module: ttt_move_sequencer
// Drives the tic-tac-toe core move interface: validates one player request, picks the
// computer reply, strobes play then comp, waits for the core to settle, and stops in
// DONE once the core reports a result.
//   clock, reset_n      clock and asynchronous active-low reset
//   btn_valid, btn_pos  one-cycle player move request, cell 0..8
//   board, winner       board state and result from the core
//   play, comp          one-cycle move strobes to the core
//   player, computer    cells presented to the core with the strobes
//   busy                high in every state except idle
//   illegal             one-cycle pulse when a request is rejected
//   game_over           high once the game has ended
module ttt_move_sequencer
    import ttt_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned STRATEGY   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        btn_valid,
    input  logic [3:0]  btn_pos,
    input  logic [17:0] board,
    input  logic [1:0]  winner,
    output logic        play,
    output logic        comp,
    output logic [3:0]  player,
    output logic [3:0]  computer,
    output logic        busy,
    output logic        illegal,
    output logic        game_over
);

    typedef enum logic [2:0] {
        StIdle,
        StPick,
        StPlay,
        StComp,
        StSettle,
        StDone
    } state_e;

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

    state_e      r_state,    w_state_next;
    logic [3:0]  r_player,   w_player_next;
    logic [3:0]  r_computer, w_computer_next;
    logic [17:0] r_board,    w_board_next;
    logic        r_skip,     w_skip_next;
    logic        r_illegal,  w_illegal_next;
    logic [3:0]  r_settle,   w_settle_next;

    logic        w_legal;
    logic [17:0] w_overlay;
    logic [3:0]  w_pick;

    // cell_at reports out-of-range positions as occupied, covering btn_pos > 8.
    assign w_legal = (btn_pos <= 4'd8) && (cell_at(board, btn_pos) == CellEmpty) &&
                     (winner == WinNone);

    // Board as it will look once the accepted player move lands.
    always_comb begin
        w_overlay = r_board;
        for (int k = 0; k < NumCells; k++) begin
            if (r_player == 4'(k)) w_overlay[2*k +: 2] = CellPlayer;
        end
    end

    ttt_move_pick u_pick (
        .i_board    (w_overlay),
        .i_strategy (STRATEGY != 0),
        .o_cell     (w_pick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_player   <= 4'd0;
            r_computer <= 4'd0;
            r_board    <= '0;
            r_skip     <= 1'b0;
            r_illegal  <= 1'b0;
            r_settle   <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_player   <= w_player_next;
            r_computer <= w_computer_next;
            r_board    <= w_board_next;
            r_skip     <= w_skip_next;
            r_illegal  <= w_illegal_next;
            r_settle   <= w_settle_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_player_next   = r_player;
        w_computer_next = r_computer;
        w_board_next    = r_board;
        w_skip_next     = r_skip;
        w_illegal_next  = 1'b0;
        w_settle_next   = r_settle;

        unique case (r_state)
            StIdle: begin
                if (btn_valid) begin
                    if (w_legal) begin
                        w_player_next = btn_pos;
                        w_board_next  = board;
                        w_state_next  = StPick;
                    end else begin
                        w_illegal_next = 1'b1;
                    end
                end
            end
            StPick: begin
                w_computer_next = w_pick;
                // No reply when the player just won or filled the last cell.
                w_skip_next     = line_win(w_overlay, CellPlayer) || (w_pick == NoCell);
                w_state_next    = StPlay;
            end
            StPlay: begin
                w_state_next = StComp;
            end
            StComp: begin
                w_settle_next = 4'd0;
                w_state_next  = StSettle;
            end
            StSettle: begin
                if (r_settle == SettleLast) begin
                    w_state_next = (winner != WinNone) ? StDone : StIdle;
                end else begin
                    w_settle_next = r_settle + 4'd1;
                end
            end
            StDone: begin
                if (btn_valid) w_illegal_next = 1'b1;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        play      = (r_state == StPlay);
        comp      = (r_state == StComp) && !r_skip;
        busy      = (r_state != StIdle);
        game_over = (r_state == StDone);
        illegal   = r_illegal;
        player    = r_player;
        computer  = r_computer;
    end

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Testbench: tb_ttt_move_sequencer
// Scoreboard bench: each driven request pushes its expected outcome; a negedge monitor
// pops and compares when the DUT answers with illegal or play. A second instance with
// SETTLE_CYC=5 checks the settle-length dependent return to idle.
module tb_ttt_move_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_valid = 1'b0;
    logic [3:0]  btn_pos = 4'd0;
    logic [17:0] board = '0;
    logic [1:0]  winner = 2'b00;

    logic       play, comp, busy, illegal, game_over;
    logic [3:0] player, computer;
    logic       play_5, comp_5, busy_5, illegal_5, game_over_5;
    logic [3:0] player_5, computer_5;

    always #5 clock = ~clock;

    ttt_move_sequencer #(.SETTLE_CYC(2), .STRATEGY(1)) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_valid (btn_valid),
        .btn_pos   (btn_pos),
        .board     (board),
        .winner    (winner),
        .play      (play),
        .comp      (comp),
        .player    (player),
        .computer  (computer),
        .busy      (busy),
        .illegal   (illegal),
        .game_over (game_over)
    );

    ttt_move_sequencer #(.SETTLE_CYC(5), .STRATEGY(1)) u_dut_s5 (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_valid (btn_valid),
        .btn_pos   (btn_pos),
        .board     (board),
        .winner    (winner),
        .play      (play_5),
        .comp      (comp_5),
        .player    (player_5),
        .computer  (computer_5),
        .busy      (busy_5),
        .illegal   (illegal_5),
        .game_over (game_over_5)
    );

    typedef struct {
        logic       ill;
        logic [3:0] ply;
        logic [3:0] cmp;
        logic       fire;
        int         k;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    logic comp_pending = 1'b0;
    logic comp_exp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // '.' empty, 'P' player, 'C' computer, 'X' illegal code; char k is cell k.
    function automatic logic [17:0] mk_board(input string s);
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) begin
            case (s[k])
                "P":     b[2*k +: 2] = 2'b01;
                "C":     b[2*k +: 2] = 2'b10;
                "X":     b[2*k +: 2] = 2'b11;
                default: b[2*k +: 2] = 2'b00;
            endcase
        end
        return b;
    endfunction

    task automatic send(input logic [3:0] pos, input logic ill, input logic [3:0] cmp,
                        input logic fire, output int k);
        exp_t e;
        @(posedge clock); #1;
        btn_valid = 1'b1;
        btn_pos   = pos;
        k         = cyc;
        e.ill = ill; e.ply = pos; e.cmp = cmp; e.fire = fire; e.k = k;
        q_exp.push_back(e);
        @(posedge clock); #1;
        btn_valid = 1'b0;
    endtask

    // Request with no expected response (DUT busy).
    task automatic poke(input logic [3:0] pos);
        btn_valid = 1'b1;
        btn_pos   = pos;
        @(posedge clock); #1;
        btn_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (busy && i < 50) begin
            @(negedge clock);
            i++;
        end
        check_eq("idle_timeout", busy, 0);
        @(negedge clock);
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                comp_pending = 1'b0;
            end else begin
                if (comp_pending) begin
                    check_eq("comp_strobe", comp, comp_exp);
                    check_eq("play_width", play, 0);
                    comp_pending = 1'b0;
                end else if (comp) begin
                    check_eq("spurious_comp", comp, 0);
                end
                if (illegal) begin
                    if (q_exp.size() == 0) begin
                        check_eq("spurious_illegal", illegal, 0);
                    end else begin
                        e = q_exp.pop_front();
                        check_eq("illegal_expected", illegal, e.ill);
                        check_eq("illegal_latency", cyc, e.k + 1);
                    end
                end
                if (play) begin
                    if (q_exp.size() == 0) begin
                        check_eq("spurious_play", play, 0);
                    end else begin
                        e = q_exp.pop_front();
                        check_eq("play_expected", play, !e.ill);
                        check_eq("player_cell", player, e.ply);
                        check_eq("computer_cell", computer, e.cmp);
                        check_eq("play_latency", cyc, e.k + 2);
                        comp_pending = 1'b1;
                        comp_exp     = e.fire;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t_main;
        int t_s5;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_play", play, 0);
        check_eq("rst_comp", comp, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_game_over", game_over, 0);
        check_eq("rst_player", player, 0);
        check_eq("rst_computer", computer, 0);
        reset_n = 1'b1;

        // Asynchronous reset in the middle of SETTLE
        board = mk_board(".........");
        send(4'd3, 1'b0, 4'd4, 1'b1, k);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_busy", busy, 0);
        check_eq("async_player", player, 0);
        check_eq("async_computer", computer, 0);
        check_eq("async_play", play, 0);
        check_eq("async_comp", comp, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Empty board, corner move; idle re-entry for both settle lengths
        send(4'd0, 1'b0, 4'd4, 1'b1, k);
        t_main = -1;
        t_s5   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!busy && t_main < 0) t_main = cyc;
            if (!busy_5 && t_s5 < 0) t_s5 = cyc;
            if (t_main >= 0 && t_s5 >= 0) break;
        end
        check_eq("idle_latency_s2", t_main, k + 6);
        check_eq("idle_latency_s5", t_s5, k + 9);

        // Rejections: occupied cell, out-of-range cell, illegal cell code
        board = mk_board("....P....");
        send(4'd4, 1'b1, 4'd0, 1'b0, k);
        repeat (2) @(negedge clock);
        send(4'd9, 1'b1, 4'd0, 1'b0, k);
        repeat (2) @(negedge clock);
        // Legal move needing a block at 8; extra request while busy is dropped
        send(4'd0, 1'b0, 4'd8, 1'b1, k);
        poke(4'd2);
        wait_idle();
        board = mk_board("....X....");
        send(4'd4, 1'b1, 4'd0, 1'b0, k);
        repeat (2) @(negedge clock);
        send(4'd0, 1'b0, 4'd2, 1'b1, k);
        wait_idle();

        // Block, then win beats block
        board = mk_board("P...C....");
        send(4'd1, 1'b0, 4'd2, 1'b1, k);
        wait_idle();
        board = mk_board("P..CC....");
        send(4'd1, 1'b0, 4'd5, 1'b1, k);
        wait_idle();

        // Player completes a diagonal: no comp strobe, then DONE
        board = mk_board("P...P....");
        send(4'd8, 1'b0, 4'd2, 1'b0, k);
        @(posedge clock); #1;
        winner = 2'b01;
        repeat (6) @(negedge clock);
        check_eq("win_game_over", game_over, 1);
        check_eq("win_busy", busy, 1);
        send(4'd3, 1'b1, 4'd0, 1'b0, k);
        repeat (2) @(negedge clock);
        check_eq("win_game_over_hold", game_over, 1);

        // Ninth cell filled by player: no free cell, comp suppressed, draw -> DONE
        reset_n = 1'b0;
        winner  = 2'b00;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check_eq("rerst_game_over", game_over, 0);
        board = mk_board("PCPPCCCP.");
        send(4'd8, 1'b0, 4'hF, 1'b0, k);
        @(posedge clock); #1;
        winner = 2'b11;
        repeat (6) @(negedge clock);
        check_eq("draw_game_over", game_over, 1);
        check_eq("draw_busy", busy, 1);

        repeat (2) @(negedge clock);
        check_eq("queue_empty", q_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
